step_sequencer: RTL

//  Timing-state generator for the multicycle processor control unit. Runs a 4-bit

---
 rtl/step_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// T-state generator for the multicycle control unit: a 4-bit step counter with a one-hot
// decode, per-instruction length, stall hold, abort and back-to-back restart.
module step_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       end_step,
  input  logic             stall,
  input  logic             abort,
  output logic [15:0]      t,
  output logic [3:0]       step,
  output logic             busy,
  output logic             waiting,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       last_q, last_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      t_q, t_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRun;
          step_d  = 4'd0;
          last_d  = end_step;
        end
      end
      StRun, StHold: begin
        if (abort) begin
          state_d = StIdle;
          step_d  = 4'd0;
        end else if (stall) begin
          state_d = StHold;
        end else if (step_q != last_q) begin
          state_d = StRun;
          step_d  = step_q + 4'd1;
        end else begin
          // Finishing edge: a pending start restarts at T0 with no idle gap.
          done_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          step_d = 4'd0;
          if (start) begin
            state_d = StRun;
            last_d  = end_step;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        step_d  = 4'd0;
      end
    endcase

    t_d = (state_d != StIdle) ? (16'h0001 << step_d) : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= 4'd0;
      last_q  <= 4'd0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      t_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
    end
  end

  assign t         = t_q;
  assign step      = step_q;
  assign busy      = (state_q == StRun) || (state_q == StHold);
  assign waiting   = (state_q == StHold);
  assign done      = done_q;
  assign instr_cnt = cnt_q;

endmodule
